vga_hsync_rx: RTL and testbench

//   Receive-side horizontal timing recovery for the VGA path. Samples an incoming

---
 rtl/vga_hsync_rx.sv | 157 +++++++++++++++
 tb/tb_vga_hsync_rx.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/vga_hsync_rx.sv
// Horizontal timing recovery: measures hsync width and line period, locks after stable lines,
// then regenerates the visible-pixel window. First valid pixel comes BACK+2 cycles after hsync rise is sampled. No backpressure.
module vga_hsync_rx #(
    parameter int unsigned FRONT      = 48,
    parameter int unsigned BACK       = 248,
    parameter int unsigned SYNC       = 112,
    parameter int unsigned VISIBLE    = 1280,
    parameter int unsigned LOCK_LINES = 4,
    parameter int unsigned CW         = 16
) (
    input  logic          clk_i,
    input  logic          reset_ni,
    input  logic          hsync_i,
    output logic          locked_o,
    output logic          hpixel_valid_o,
    output logic [CW-1:0] hpixel_x_o,
    output logic          line_start_o,
    output logic [CW-1:0] sync_len_o,
    output logic [CW-1:0] line_len_o,
    output logic          timing_err_o
);
    localparam int unsigned   TOTAL_I  = FRONT + BACK + SYNC + VISIBLE;
    localparam logic [CW-1:0] TOTAL    = CW'(TOTAL_I);
    localparam logic [CW-1:0] LINE_MAX = CW'(2 * TOTAL_I);
    localparam logic [CW-1:0] SYNC_W   = CW'(SYNC);
    localparam logic [CW-1:0] WIN_LO   = CW'(BACK);
    localparam logic [CW-1:0] WIN_HI   = CW'(BACK + VISIBLE);
    localparam logic [CW-1:0] COL_MAX  = {CW{1'b1}};
    localparam logic [CW-1:0] ONE      = CW'(1);
    localparam logic [3:0]    LOCK_N   = 4'(LOCK_LINES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SYNC = 2'd1;
    localparam logic [1:0] ST_LINE = 2'd2;

    logic          hs1_q, hs2_q;
    logic [1:0]    state_q, state_d;
    logic [CW-1:0] sync_cnt_q, sync_cnt_d;
    logic [CW-1:0] line_cnt_q, line_cnt_d;
    logic [CW-1:0] col_q, col_d;
    logic [3:0]    good_q, good_d, good_inc;
    logic          locked_q, locked_d;
    logic [CW-1:0] sync_len_q, sync_len_d;
    logic [CW-1:0] line_len_q, line_len_d;
    logic          err_d;
    logic          timing_err_q, line_start_q, hpixel_valid_q;
    logic [CW-1:0] hpixel_x_q;
    logic          fall, rise, in_win;

    assign fall = hs2_q & ~hs1_q;
    assign rise = ~hs2_q & hs1_q;

    always_comb begin
        state_d    = state_q;
        sync_cnt_d = sync_cnt_q;
        line_cnt_d = line_cnt_q;
        col_d      = col_q;
        good_d     = good_q;
        locked_d   = locked_q;
        sync_len_d = sync_len_q;
        line_len_d = line_len_q;
        err_d      = 1'b0;
        good_inc   = (good_q >= LOCK_N) ? good_q : good_q + 4'd1;
        in_win     = locked_q && (state_q == ST_LINE) && (col_q >= WIN_LO) && (col_q < WIN_HI);

        case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d    = ST_SYNC;
                    sync_cnt_d = ONE;
                    line_cnt_d = ONE;
                end
            end
            ST_SYNC: begin
                sync_cnt_d = sync_cnt_q + ONE;
                line_cnt_d = line_cnt_q + ONE;
                if (rise) begin
                    state_d    = ST_LINE;
                    sync_len_d = sync_cnt_q;
                    col_d      = '0;
                end else if (sync_cnt_q == TOTAL) begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                    good_d   = '0;
                    err_d    = 1'b1;
                end
            end
            ST_LINE: begin
                line_cnt_d = line_cnt_q + ONE;
                col_d      = (col_q == COL_MAX) ? col_q : col_q + ONE;
                if (fall) begin
                    // The line just finished is judged here; lock only moves on this edge.
                    line_len_d = line_cnt_q;
                    state_d    = ST_SYNC;
                    sync_cnt_d = ONE;
                    line_cnt_d = ONE;
                    if ((line_cnt_q == TOTAL) && (sync_len_q == SYNC_W)) begin
                        good_d   = good_inc;
                        locked_d = (good_inc == LOCK_N);
                    end else begin
                        good_d   = '0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end else if (line_cnt_q == LINE_MAX) begin
                    state_d  = ST_IDLE;
                    locked_d = 1'b0;
                    good_d   = '0;
                    err_d    = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            hs1_q          <= 1'b1;
            hs2_q          <= 1'b1;
            state_q        <= ST_IDLE;
            sync_cnt_q     <= '0;
            line_cnt_q     <= '0;
            col_q          <= '0;
            good_q         <= '0;
            locked_q       <= 1'b0;
            sync_len_q     <= '0;
            line_len_q     <= '0;
            timing_err_q   <= 1'b0;
            line_start_q   <= 1'b0;
            hpixel_valid_q <= 1'b0;
            hpixel_x_q     <= '0;
        end else begin
            hs1_q          <= hsync_i;
            hs2_q          <= hs1_q;
            state_q        <= state_d;
            sync_cnt_q     <= sync_cnt_d;
            line_cnt_q     <= line_cnt_d;
            col_q          <= col_d;
            good_q         <= good_d;
            locked_q       <= locked_d;
            sync_len_q     <= sync_len_d;
            line_len_q     <= line_len_d;
            timing_err_q   <= err_d;
            line_start_q   <= fall;
            hpixel_valid_q <= in_win;
            hpixel_x_q     <= in_win ? col_q - WIN_LO : '0;
        end
    end

    assign locked_o       = locked_q;
    assign hpixel_valid_o = hpixel_valid_q;
    assign hpixel_x_o     = hpixel_x_q;
    assign line_start_o   = line_start_q;
    assign sync_len_o     = sync_len_q;
    assign line_len_o     = line_len_q;
    assign timing_err_o   = timing_err_q;
endmodule

// File: tb/tb_vga_hsync_rx.sv
// Bench for vga_hsync_rx: directed lines, expected events queued by stimulus and checked by a monitor.
module tb_vga_hsync_rx;
    localparam int CW      = 16;
    localparam int BACK    = 248;
    localparam int VISIBLE = 1280;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          hsync;
    logic          locked, hpixel_valid, line_start, timing_err;
    logic [CW-1:0] hpixel_x, sync_len, line_len;

    vga_hsync_rx dut (
        .clk_i          (clk),
        .reset_ni       (reset_n),
        .hsync_i        (hsync),
        .locked_o       (locked),
        .hpixel_valid_o (hpixel_valid),
        .hpixel_x_o     (hpixel_x),
        .line_start_o   (line_start),
        .sync_len_o     (sync_len),
        .line_len_o     (line_len),
        .timing_err_o   (timing_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; int lk; int ll; int sl; } ls_rec_t;
    typedef struct { int cyc; int len; } win_rec_t;

    ls_rec_t  ls_q[$];
    int       err_q[$];
    win_rec_t win_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    task automatic unexpected(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: unexpected event at cycle %0d (got 1, expected 0)", name, cyc);
    endtask

    // Monitor: pops an expectation whenever the DUT presents an event.
    bit in_win = 0;
    int win_len, x_bad;
    win_rec_t cur_win;
    always @(negedge clk) begin
        if (line_start) begin
            if (ls_q.size() == 0) unexpected("line_start");
            else begin
                ls_rec_t r;
                r = ls_q.pop_front();
                check("line_start_cycle", cyc, r.cyc);
                check("locked_at_fall", int'(locked), r.lk);
                check("line_len", int'(line_len), r.ll);
                check("sync_len", int'(sync_len), r.sl);
            end
        end
        if (timing_err) begin
            if (err_q.size() == 0) unexpected("timing_err");
            else begin
                check("timing_err_cycle", cyc, err_q.pop_front());
                check("locked_at_err", int'(locked), 0);
            end
        end
        if (hpixel_valid) begin
            if (!in_win) begin
                in_win  = 1;
                win_len = 0;
                x_bad   = 0;
                if (win_q.size() == 0) begin
                    unexpected("hpixel_valid");
                    cur_win = '{cyc, -1};
                end else begin
                    cur_win = win_q.pop_front();
                    check("window_start", cyc, cur_win.cyc);
                end
            end
            if (int'(hpixel_x) != win_len) x_bad++;
            win_len++;
        end else if (in_win) begin
            in_win = 0;
            if (cur_win.len >= 0) begin
                check("window_len", win_len, cur_win.len);
                check("hpixel_x_seq_errors", x_bad, 0);
                check("hpixel_x_after_window", int'(hpixel_x), 0);
            end
        end
    end

    task automatic hold(input logic v, input int n);
        hsync = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Expected values at this line's starting fall describe the previous line.
    task automatic send_line(input int low, input int high, input int lk, input int ll,
                             input int sl, input bit err, input bit win);
        ls_q.push_back('{cyc + 2, lk, ll, sl});
        if (err) err_q.push_back(cyc + 2);
        hold(1'b0, low);
        if (win) win_q.push_back('{cyc + BACK + 3, VISIBLE});
        hold(1'b1, high);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_locked"}, int'(locked), 0);
        check({tag, "_valid"}, int'(hpixel_valid), 0);
        check({tag, "_x"}, int'(hpixel_x), 0);
        check({tag, "_line_start"}, int'(line_start), 0);
        check({tag, "_sync_len"}, int'(sync_len), 0);
        check({tag, "_line_len"}, int'(line_len), 0);
        check({tag, "_err"}, int'(timing_err), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        hsync   = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset_n = 1'b1;
        hold(1'b1, 10);

        // Initial acquisition: lock at the 5th fall.
        send_line(112, 1576, 0, 0,    0,   0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 1, 1688, 112, 0, 1);
        send_line(112, 1576, 1, 1688, 112, 0, 1);

        // One 113-cycle sync line, then re-lock over 4 good lines.
        send_line(113, 1575, 1, 1688, 112, 0, 1);
        send_line(112, 1576, 0, 1688, 113, 1, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 1, 1688, 112, 0, 1);
        send_line(112, 1576, 1, 1688, 112, 0, 1);

        // hsync stuck high: timeout 2*TOTAL = 3376 cycles after the line start.
        err_q.push_back(cyc + 2 + 3376);
        send_line(112, 4000, 1, 1688, 112, 0, 1);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 1, 1688, 112, 0, 1);

        // One-cycle reset 600 pixels into a locked visible window.
        ls_q.push_back('{cyc + 2, 1, 1688, 112});
        hold(1'b0, 112);
        win_q.push_back('{cyc + BACK + 3, 601});
        hold(1'b1, BACK + 3 + 600);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        check_all_zero("midline_reset");
        reset_n = 1'b1;
        hold(1'b1, 724);

        send_line(112, 1576, 0, 0,    0,   0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 0, 1688, 112, 0, 0);
        send_line(112, 1576, 1, 1688, 112, 0, 1);
        hold(1'b1, 20);

        check("pending_line_starts", ls_q.size(), 0);
        check("pending_errors", err_q.size(), 0);
        check("pending_windows", win_q.size(), 0);
        check("window_open_at_end", int'(in_win), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
